muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle execute-stage unit that consumes the ALU selection codes for the M extension (`ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU, `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU from defines.v) and produces the 32-bit result.
- Sits beside the single-cycle ALU in EX.
- The hazard unit stalls the pipeline on busy and captures result on done.
- Uses radix-2 iterative shift-add multiply and restoring divide.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  abort in-flight op (branch/exception flush).
- alu_sel  input  5  ALU selection code from the ALU control unit.
- rs1_val  input  XLEN  operand A (multiplicand/dividend).
- rs2_val  input  XLEN  operand B (multiplier/divisor).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse; result is valid this cycle.
- result  output  XLEN  final value; held until the next accepted start.

Behaviour:
- Reset:
  - Behaviour is the same for reset in any state, including mid-operation.
  - Next state IDLE; busy=0, done=0, result=0, counter=0, internal registers cleared.
- States are IDLE, CALC, FIN.
- IDLE:
  - start=1 and flush=0: latch alu_sel/rs1_val/rs2_val and go to CALC.
  - start=1 and flush=1 in the same cycle: flush wins, nothing is accepted.
- Sign preparation in the accept cycle:
  - MULH: both operands are signed.
  - MULHSU: A is signed, B is unsigned.
  - DIV and REM: both operands are signed.
  - All signed operands are converted to magnitude; neg_res and neg_rem flags are stored.
- Special cases are resolved in the accept cycle and go straight to FIN (done at cycle 1):
  - Divisor==0: DIV/DIVU → all ones; REM/REMU → rs1_val.
  - DIV with A=0x80000000 and B=0xFFFFFFFF → 0x80000000; REM in the same case → 0.
  - Any alu_sel that is not an M code → result 0.
- CALC: counter runs 0..XLEN-1, one iteration per cycle.
  - Multiply keeps a 2*XLEN product register.
  - Divide keeps XLEN quotient and XLEN+1 partial remainder registers.
- FIN:
  - Apply the sign fix as two's complement of the 64-bit product, quotient, or remainder.
  - Select the low word for MUL and the high word for MULH/MULHSU/MULHU.
  - Register result and pulse done=1 for one cycle, then return to IDLE.
- Latency: accept at cycle 0 → done at cycle XLEN+1 (33).
- busy=1 in CALC and FIN; done and busy are never high in the same cycle.
- Next start can be accepted in the cycle after done (back-to-back).
- start while busy=1 is ignored; no queuing.
- flush in CALC/FIN:
  - Next state IDLE, busy=0, no done pulse.
  - result keeps its prior value.
- Remainder sign follows the dividend; quotient rounds toward zero.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a combinational XLEN×XLEN (2*XLEN-bit) signed/unsigned multiplier in the accept cycle.
  - Multiply ops go directly to FIN, so done is at cycle 1.
  - Divide behaviour is unchanged.
- Undefined: multiply uses the iterative CALC path, with done at cycle 33.
- All results are identical with or without the macro.

Test Plan:
- Signed multiply:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; done at cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN).
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF with done at cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush and reset:
  - Start DIVU; assert flush at cycle 10 → busy=0 at cycle 11, no done, result unchanged.
  - rst at cycle 20 of a new op → all outputs 0 on the next cycle.
- Handshake:
  - start held high for 40 cycles → exactly one op per done.
  - Second op accepted the cycle after done; start during busy ignored.
  - start+flush together in IDLE → no op.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide beside the EX-stage ALU.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divide unchanged).
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state, state_nx;

  logic [4:0]        op;
  logic              mul_q;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   opd;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res;
  logic              neg_rem;

  logic            is_mul;
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            known;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div0;
  logic            ovf;
  logic            fast;
  logic            direct;
  logic            accept;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    known  = 1'b1;
    unique case (alu_sel)
      ALU_MUL, ALU_MULHU: is_mul = 1'b1;
      ALU_MULH: begin
        is_mul = 1'b1;
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
      end
      ALU_MULHSU: begin
        is_mul = 1'b1;
        sgn_a  = 1'b1;
      end
      ALU_DIV, ALU_REM: begin
        is_div = 1'b1;
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
      end
      ALU_DIVU, ALU_REMU: is_div = 1'b1;
      default: known = 1'b0;
    endcase
  end

  assign neg_a = sgn_a & rs1_val[XLEN-1];
  assign neg_b = sgn_b & rs2_val[XLEN-1];
  assign mag_a = neg_a ? -rs1_val : rs1_val;
  assign mag_b = neg_b ? -rs2_val : rs2_val;
  assign div0  = is_div & (rs2_val == '0);
  assign ovf   = is_div & sgn_a
               & (rs1_val == {1'b1, {(XLEN-1){1'b0}}})
               & (rs2_val == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fprod;
  assign fprod = $signed({neg_a, rs1_val})
               * $signed({neg_b, rs2_val});
  assign fast = is_mul;
`else
  assign fast = 1'b0;
`endif

  assign direct = ~known | div0 | ovf | fast;
  assign accept = (state == IDLE) & start & ~flush;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !flush)
              state_nx = direct ? FIN : CALC;
      CALC: if (flush)
              state_nx = IDLE;
            else if (cnt == CNT_W'(XLEN-1))
              state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [XLEN:0]     msum;
  logic [XLEN+1:0]   shl;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] pfix;
  logic [XLEN-1:0]   qfix;
  logic [XLEN-1:0]   rfix;
  logic [XLEN-1:0]   fin_val;

  assign msum = {1'b0, prod[2*XLEN-1:XLEN]}
              + {1'b0, (prod[0] ? opd : '0)};
  assign shl  = {rem, quo[XLEN-1]};
  assign diff = shl - {2'b00, opd};
  assign pfix = neg_res ? -prod : prod;
  assign qfix = neg_res ? -quo : quo;
  assign rfix = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  always_comb begin
    fin_val = '0;
    unique case (op)
      ALU_MUL: fin_val = pfix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:
        fin_val = pfix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU: fin_val = qfix;
      ALU_REM, ALU_REMU: fin_val = rfix;
      default: fin_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      mul_q   <= 1'b0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      opd     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op      <= known ? alu_sel : ALU_MUL;
        mul_q   <= is_mul;
        cnt     <= '0;
        neg_res <= neg_a ^ neg_b;
        neg_rem <= neg_a;
        prod    <= {{XLEN{1'b0}}, mag_b};
        quo     <= mag_a;
        rem     <= '0;
        opd     <= is_mul ? mag_a : mag_b;
        // Special cases preload the final value so FIN is uniform.
        if (!known) begin
          prod    <= '0;
          neg_res <= 1'b0;
        end else if (div0) begin
          quo     <= '1;
          rem     <= {1'b0, rs1_val};
          neg_res <= 1'b0;
          neg_rem <= 1'b0;
        end else if (ovf) begin
          quo     <= rs1_val;
          rem     <= '0;
          neg_res <= 1'b0;
          neg_rem <= 1'b0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (is_mul) begin
          prod    <= fprod[2*XLEN-1:0];
          neg_res <= 1'b0;
        end
`endif
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (mul_q) begin
          prod <= {msum, prod[XLEN-1:1]};
        end else if (!diff[XLEN+1]) begin
          rem <= diff[XLEN:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          rem <= shl[XLEN:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end else if (state == FIN && !flush) begin
        result <= fin_val;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency,
// flush, reset and start handshake (honours MULDIV_FAST_MUL_EN).
module tb_muldiv_unit;

  localparam logic [4:0] MUL    = 5'd10;
  localparam logic [4:0] MULH   = 5'd11;
  localparam logic [4:0] MULHSU = 5'd12;
  localparam logic [4:0] MULHU  = 5'd13;
  localparam logic [4:0] DIV    = 5'd14;
  localparam logic [4:0] DIVU   = 5'd15;
  localparam logic [4:0] REM    = 5'd16;
  localparam logic [4:0] REMU   = 5'd17;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  alu_sel = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .alu_sel (alu_sel),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [4:0] sel,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int lat_exp);
    int lat;
    int bad;
    lat = 0;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    alu_sel = sel;
    rs1_val = a;
    rs2_val = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        if (busy) bad++;
        break;
      end
      if (!busy) bad++;
    end
    check({tag, " lat"}, 32'(lat), 32'(lat_exp));
    check({tag, " res"}, result, exp);
    check({tag, " busy"}, 32'(bad), 32'd0);
  endtask

  int seen;
  int both;
  int accepted;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul", MUL, 32'd7, 32'hFFFF_FFFD,
           32'hFFFF_FFEB, MLAT);
    run_op("mulh", MULH, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, MLAT);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, MLAT);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, MLAT);
    run_op("mulh neg", MULH, 32'hFFFF_FFFE, 32'd3,
           32'hFFFF_FFFF, MLAT);
    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 33);
    run_op("rem", REM, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 33);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("div neg b", DIV, 32'd20, 32'hFFFF_FFFA,
           32'hFFFF_FFFD, 33);
    run_op("rem neg b", REM, 32'd20, 32'hFFFF_FFFA,
           32'd2, 33);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1);
    run_op("bad sel", 5'd3, 32'd9, 32'd9, 32'd0, 1);
    run_op("div0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0", REMU, 32'd5, 32'd0, 32'd5, 1);

    // Flush ten cycles into a divide; result must hold at 5.
    @(negedge clk);
    start = 1'b1;
    alu_sel = DIVU;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("fl busy pre", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl busy", {31'd0, busy}, 32'd0);
    check("fl result", result, 32'd5);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("fl no done", 32'(seen), 32'd0);

    // Synchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    alu_sel = DIVU;
    rs1_val = 32'd77;
    rs2_val = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst busy", {31'd0, busy}, 32'd0);
    check("mid rst done", {31'd0, done}, 32'd0);
    check("mid rst result", result, 32'd0);
    rst = 1'b0;

    // start together with flush in IDLE is dropped.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    alu_sel = DIVU;
    rs1_val = 32'd9;
    rs2_val = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("sf busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("sf done", {31'd0, done}, 32'd0);

    // start held for 40 edges: accepts at 0 and 34 only.
    @(negedge clk);
    start = 1'b1;
    alu_sel = DIVU;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    seen = 0;
    both = 0;
    accepted = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
      if (done && busy) both++;
      if (i == 34 && busy) accepted = 1;
      if (i == 39) start = 1'b0;
    end
    check("hs dones", 32'(seen), 32'd2);
    check("hs overlap", 32'(both), 32'd0);
    check("hs b2b", 32'(accepted), 32'd1);
    check("hs result", result, 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
